data_shifter_right: RTL and testbench
=====================================

DATA_SHIFTER_RIGHT -- requirements
Module: data_shifter_right

Interface
REQ-001 Parameter: IN_W, default 24, input sample width in bits.
REQ-002 Parameter: OUT_W, default 16, output sample width in bits; SHIFT is fixed at IN_W-OUT_W (8 by default).
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: data_in  input  IN_W  signed two's-complement sample.
REQ-006 Port: enn  input  1  enable; high = pass scaled sample, low = force zero output.
REQ-007 Port: data_out  output  OUT_W  registered scaled sample, two's complement.
REQ-008 Port: out_valid  output  1  registered; high when data_out holds a sample captured with enn=1.

Function
REQ-009 On each rising clk edge with enn=1, data_out SHALL load data_in[IN_W-1:SHIFT], an arithmetic right shift by SHIFT truncated to OUT_W bits, with the sign preserved.
REQ-010 On each rising clk edge with enn=1, out_valid SHALL load 1.
REQ-011 On each rising clk edge with enn=0, data_out SHALL load all zeros and out_valid SHALL load 0, regardless of data_in.
REQ-012 Latency SHALL be exactly one clock: inputs sampled at edge N appear on the outputs after edge N and hold until edge N+1.
REQ-013 The output SHALL be fully registered, with no combinational path from data_in or enn to data_out or out_valid.
REQ-014 Truncation (default build) SHALL discard data_in[SHIFT-1:0] with no rounding, so negative values round toward negative infinity (example: 0xFFFFFF gives 0xFFFF).
REQ-015 Extreme inputs: 0x7FFFFF gives 0x7FFF and 0x800000 gives 0x8000; no overflow is possible in the default build.
REQ-016 Toggling enn every cycle SHALL produce alternating sample/zero outputs with no stall or extra latency.

Reset
REQ-017 While rst=1, data_out SHALL be 0 and out_valid SHALL be 0, asynchronously and immediately, independent of clk.
REQ-018 Reset asserted mid-stream SHALL discard the held sample.
REQ-019 After rst deasserts, the first rising edge SHALL follow REQ-009 to REQ-011 normally.

Configuration
REQ-020 Macro DATA_SHIFTER_RIGHT_ROUND_EN, when defined, SHALL replace truncation with round-half-up: result = data_in[IN_W-1:SHIFT] + data_in[SHIFT-1], saturated to 0x7FFF on positive overflow.
REQ-021 With DATA_SHIFTER_RIGHT_ROUND_EN defined, the enn=0, reset and latency behaviour SHALL be unchanged.
REQ-022 With DATA_SHIFTER_RIGHT_ROUND_EN undefined, the behaviour SHALL be pure truncation per REQ-009 and REQ-014.

Verification
REQ-023 Reset and enable: assert rst with data_in=123456 and enn=1 -> data_out=0x0000 and out_valid=0 immediately; after release, data_in=123456 (0x01E240) with enn=1 -> data_out=0x01E2 and out_valid=1 one clock later.
REQ-024 Negative sample: data_in=-654321 (0xF6040F) with enn=1 -> data_out=0xF604 one clock later.
REQ-025 Disable: enn=0 with data_in=-654321 -> data_out=0x0000 and out_valid=0 after the next edge.
REQ-026 Extremes: 0x7FFFFF -> 0x7FFF; 0x800000 -> 0x8000; 0xFFFFFF -> 0xFFFF (default build).
REQ-027 Reset mid-stream: rst pulsed between edges while data_out=0x01E2 -> data_out=0x0000 without a clock edge.
REQ-028 Rounding build (macro defined): 0x000180 -> 0x0002; 0x00017F -> 0x0001; 0x7FFF80 -> 0x7FFF (saturated).

Source files
------------

// File: rtl/data_shifter_right.sv
// Registered signed right-shift scaler: IN_W-bit sample to OUT_W-bit sample, zero output when disabled.
// Define DATA_SHIFTER_RIGHT_ROUND_EN to round half-up with positive saturation instead of truncating.
module data_shifter_right #(
    parameter int IN_W  = 24,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  data_in,
    input  logic             enn,
    output logic [OUT_W-1:0] data_out,
    output logic             out_valid
);

    localparam int SHIFT = IN_W - OUT_W;

    logic [OUT_W-1:0] data_d;
    logic [OUT_W-1:0] data_q;
    logic             valid_d;
    logic             valid_q;

`ifdef DATA_SHIFTER_RIGHT_ROUND_EN
    // Adding the round bit can only overflow upward, so only positive saturation is needed.
    function automatic logic [OUT_W-1:0] scale_f(input logic [IN_W-1:0] x);
        logic [OUT_W:0] sum;
        sum = {x[IN_W-1], x[IN_W-1:SHIFT]} + {{OUT_W{1'b0}}, x[SHIFT-1]};
        if (sum[OUT_W] != sum[OUT_W-1]) begin
            scale_f = {1'b0, {(OUT_W-1){1'b1}}};
        end else begin
            scale_f = sum[OUT_W-1:0];
        end
    endfunction
`else
    function automatic logic [OUT_W-1:0] scale_f(input logic [IN_W-1:0] x);
        scale_f = x[IN_W-1:SHIFT];
    endfunction
`endif

    // Next-state selection: scaled sample when enabled, forced zero otherwise
    always_comb begin
        data_d  = {OUT_W{1'b0}};
        valid_d = 1'b0;
        if (enn) begin
            data_d  = scale_f(data_in);
            valid_d = 1'b1;
        end else begin
            data_d  = {OUT_W{1'b0}};
            valid_d = 1'b0;
        end
    end

    // Output registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= {OUT_W{1'b0}};
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_out  = data_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_data_shifter_right.sv
// Self-checking bench for data_shifter_right: directed vectors plus random stimulus
// against an arithmetic (floor-division) reference model.
module tb_data_shifter_right;

    localparam int IN_W  = 24;
    localparam int OUT_W = 16;

    logic             clk;
    logic             rst;
    logic [IN_W-1:0]  data_in;
    logic             enn;
    logic [OUT_W-1:0] data_out;
    logic             out_valid;

    int n_checks = 0;
    int n_fail   = 0;

    data_shifter_right #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .enn       (enn),
        .data_out  (data_out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: value divided by 2^SHIFT, rounded toward -inf (or half-up with saturation).
    function automatic logic [OUT_W-1:0] ref_f(input logic [IN_W-1:0] x);
        int sv;
        int div;
        int q;
        sv  = int'($signed(x));
        div = 1 << (IN_W - OUT_W);
`ifdef DATA_SHIFTER_RIGHT_ROUND_EN
        sv = sv + div / 2;
`endif
        q = sv / div;
        if (sv < 0 && (sv % div) != 0) q = q - 1;
        if (q > (1 << (OUT_W - 1)) - 1) q = (1 << (OUT_W - 1)) - 1;
        return q[OUT_W-1:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [IN_W-1:0] d, input logic e, input string tag);
        data_in = d;
        enn     = e;
        @(posedge clk);
        #1;
        check({tag, "_data"}, 32'(data_out), e ? 32'(ref_f(d)) : 32'd0);
        check({tag, "_valid"}, 32'(out_valid), 32'(e));
    endtask

    initial begin
        logic [IN_W-1:0] rd;
        logic            re;

        rst     = 1'b1;
        data_in = 24'd123456;
        enn     = 1'b1;
        #1;
        check("reset_data", 32'(data_out), 32'h0000);
        check("reset_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("reset_hold_data", 32'(data_out), 32'h0000);
        check("reset_hold_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;

        // First edge after release
        step(24'h01E240, 1'b1, "pos_sample");
        check("pos_const", 32'(data_out), 32'h01E2);

        // Reset pulsed between edges clears the held sample without a clock
        #2;
        rst = 1'b1;
        #1;
        check("midreset_data", 32'(data_out), 32'h0000);
        check("midreset_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;

        step(24'hF6040F, 1'b1, "neg_sample");
        check("neg_const", 32'(data_out), 32'hF604);
        step(24'hF6040F, 1'b0, "disable");
        step(24'h7FFFFF, 1'b1, "max_pos");
        check("max_pos_const", 32'(data_out), 32'h7FFF);
        step(24'h800000, 1'b1, "max_neg");
        check("max_neg_const", 32'(data_out), 32'h8000);
        step(24'hFFFFFF, 1'b1, "minus_one");
`ifdef DATA_SHIFTER_RIGHT_ROUND_EN
        check("minus_one_const", 32'(data_out), 32'h0000);
        step(24'h000180, 1'b1, "round_up");
        check("round_up_const", 32'(data_out), 32'h0002);
        step(24'h00017F, 1'b1, "round_down");
        check("round_down_const", 32'(data_out), 32'h0001);
        step(24'h7FFF80, 1'b1, "round_sat");
        check("round_sat_const", 32'(data_out), 32'h7FFF);
`else
        check("minus_one_const", 32'(data_out), 32'hFFFF);
        step(24'h000180, 1'b1, "trunc_180");
        check("trunc_180_const", 32'(data_out), 32'h0001);
`endif

        // Alternating enable
        for (int i = 0; i < 8; i++) begin
            rd = 24'($urandom);
            step(rd, (i % 2) == 0, "toggle");
        end

        // Random stream
        for (int i = 0; i < 200; i++) begin
            rd = 24'($urandom);
            re = ($urandom_range(0, 3) != 0);
            step(rd, re, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
